// File: rtl/cntr_pkg.sv
// Shared definitions for the rotary-switch counter front end.
// State encoding and default timing constants.
package cntr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam int unsigned DIV_DEF       = 5;
   localparam int unsigned DB_CYCLES_DEF = 4;
   localparam int unsigned RSW_W_DEF     = 4;

endpackage

// File: rtl/cntr_debounce.sv
// Two-flop synchronizer followed by a counting debouncer.
// A vector input is treated as one value: any bit change restarts the count.
module cntr_debounce #(
   parameter int unsigned WIDTH     = 1,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_db
);

   localparam int unsigned CW = $clog2(DB_CYCLES);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_sync_d;
   logic [WIDTH-1:0] r_db;
   logic [CW-1:0]    r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_sync_d <= '0;
         r_db     <= '0;
         r_cnt    <= '0;
      end else begin
         r_sync1  <= i_raw;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         // a fresh differing value counts as the first cycle of a new run
         end else if (r_sync2 != r_sync_d) begin
            r_cnt <= CW'(1);
         end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_db = r_db;

endmodule

// File: rtl/cntr_run_ctrl.sv
// Run/pause/clear controller for the rotary-switch down-counter.
// Conditions board inputs and produces the count tick, preset value and preset pulse.
module cntr_run_ctrl
   import cntr_pkg::*;
#(
   parameter int unsigned DIV       = DIV_DEF,
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
   parameter int unsigned RSW_W     = RSW_W_DEF
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             BTN_START,
   input  logic             BTN_CLR,
   input  logic [RSW_W-1:0] RSW_RAW,
   output logic             EN,
   output logic             LOAD,
   output logic [RSW_W-1:0] RSW,
   output logic             RUNNING
);

   localparam int unsigned PW = $clog2(DIV);

   logic             w_db_start;
   logic             w_db_clr;
   logic [RSW_W-1:0] w_db_rsw;
   logic             r_db_start_d;
   logic             r_db_clr_d;
   logic             w_start_p;
   logic             w_clr_p;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PW-1:0]    r_pcnt;
   logic [PW-1:0]    w_pcnt_nxt;
   logic [RSW_W-1:0] r_rsw;
   logic [RSW_W-1:0] w_rsw_nxt;
   logic             r_load;
   logic             w_load_nxt;
   logic             r_running;

   cntr_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES)) u_db_start (
      .i_clk (CLOCK),
      .i_rst (RESET),
      .i_raw (BTN_START),
      .o_db  (w_db_start)
   );

   cntr_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES)) u_db_clr (
      .i_clk (CLOCK),
      .i_rst (RESET),
      .i_raw (BTN_CLR),
      .o_db  (w_db_clr)
   );

   cntr_debounce #(.WIDTH(RSW_W), .DB_CYCLES(DB_CYCLES)) u_db_rsw (
      .i_clk (CLOCK),
      .i_rst (RESET),
      .i_raw (RSW_RAW),
      .o_db  (w_db_rsw)
   );

   assign w_start_p = w_db_start & ~r_db_start_d;
   assign w_clr_p   = w_db_clr & ~r_db_clr_d;

   always_comb begin
      w_state_nxt = r_state;
      w_pcnt_nxt  = r_pcnt;
      w_rsw_nxt   = r_rsw;
      w_load_nxt  = 1'b0;
      if (r_state == ST_RUN) begin
         w_pcnt_nxt = (r_pcnt == PW'(DIV - 1)) ? '0 : r_pcnt + PW'(1);
      end
      if (w_clr_p) begin
         w_state_nxt = ST_IDLE;
         w_rsw_nxt   = w_db_rsw;
         w_load_nxt  = 1'b1;
      end else begin
         case (r_state)
            // a switch change coinciding with START is dropped so no LOAD lands in RUN
            ST_IDLE: begin
               if (w_start_p) begin
                  w_state_nxt = ST_RUN;
                  w_pcnt_nxt  = '0;
               end else if (w_db_rsw != r_rsw) begin
                  w_rsw_nxt  = w_db_rsw;
                  w_load_nxt = 1'b1;
               end
            end
            ST_RUN: begin
               if (w_start_p) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
               if (w_start_p) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_db_start_d <= 1'b0;
         r_db_clr_d   <= 1'b0;
         r_state      <= ST_IDLE;
         r_pcnt       <= '0;
         r_rsw        <= '0;
         r_load       <= 1'b0;
         r_running    <= 1'b0;
      end else begin
         r_db_start_d <= w_db_start;
         r_db_clr_d   <= w_db_clr;
         r_state      <= w_state_nxt;
         r_pcnt       <= w_pcnt_nxt;
         r_rsw        <= w_rsw_nxt;
         r_load       <= w_load_nxt;
         r_running    <= (w_state_nxt == ST_RUN);
      end
   end

   assign EN      = (r_state == ST_RUN) && (r_pcnt == PW'(DIV - 1)) && !w_clr_p;
   assign LOAD    = r_load;
   assign RSW     = r_rsw;
   assign RUNNING = r_running;

endmodule
